// File: rtl/lcd_pkg.sv
// Shared encodings, power-on/config tables and timing constants (in microseconds)
// for the 4-bit character-LCD controller.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    CFG_HI,
    CFG_GAP,
    CFG_LO,
    CFG_WAIT,
    IDLE,
    TX_HI,
    TX_GAP,
    TX_LO,
    TX_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {
    NW_IDLE,
    NW_SETUP,
    NW_PULSE,
    NW_HOLD
  } nw_phase_e;

  localparam int unsigned T_PWR_US  = 15000;
  localparam int unsigned T_4100_US = 4100;
  localparam int unsigned T_100_US  = 100;
  localparam int unsigned T_40_US   = 40;
  localparam int unsigned T_1640_US = 1640;
  localparam int unsigned T_GAP_US  = 1;

  function automatic logic [3:0] init_nibble(input logic [1:0] step);
    logic [3:0] n;
    case (step)
      2'd3:    n = 4'h2;
      default: n = 4'h3;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Clear display / return home need the long execution time.
  function automatic logic is_slow_opcode(input logic rs, input logic [7:0] d);
    return (!rs) && (d inside {8'h01, 8'h02, 8'h03});
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one nibble onto the LCD bus: setup, enable pulse, one hold cycle.
// Reused by the power-on, configuration and byte-transfer paths.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned E_PULSE_CYC = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d
);

  localparam int unsigned MAX_CYC = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
  localparam int unsigned WC_W    = $clog2(MAX_CYC + 1);
  localparam logic [WC_W-1:0] LD_SETUP = WC_W'(SETUP_CYC - 1);
  localparam logic [WC_W-1:0] LD_PULSE = WC_W'(E_PULSE_CYC - 1);

  nw_phase_e       phase_q, phase_d;
  logic [WC_W-1:0] cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic [3:0]      nib_q, nib_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    unique case (phase_q)
      NW_IDLE: begin
        if (start) begin
          phase_d = NW_SETUP;
          cnt_d   = LD_SETUP;
          rs_d    = rs;
          nib_d   = nibble;
        end
      end
      NW_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = NW_PULSE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - WC_W'(1);
        end
      end
      NW_PULSE: begin
        if (cnt_q == '0) phase_d = NW_HOLD;
        else             cnt_d   = cnt_q - WC_W'(1);
      end
      NW_HOLD: phase_d = NW_IDLE;
      default: phase_d = NW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= NW_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
    end
  end

  // rs stays at the last written value so it covers the gap between nibbles.
  assign done   = (phase_q == NW_HOLD);
  assign lcd_e  = (phase_q == NW_PULSE);
  assign lcd_rs = rs_q;
  assign lcd_d  = (phase_q == NW_IDLE) ? 4'h0 : nib_q;

endmodule

// File: rtl/lcd_ctrl_4bit.sv
// 4-bit character-LCD controller: power-on nibble sequence, optional auto
// configuration, then valid/ready byte transfers sent as two timed nibbles.
module lcd_ctrl_4bit
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned E_PULSE_CYC = 12,
  parameter int unsigned SETUP_CYC   = 2,
  parameter bit          AUTO_CONFIG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  // Handshake: a byte is taken on the edge where cmd_valid && cmd_ready; cmd_ready
  // is high only in IDLE, so one byte is accepted per IDLE visit.
  localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned T_PWR  = T_PWR_US  * CYC_PER_US;
  localparam int unsigned T_4100 = T_4100_US * CYC_PER_US;
  localparam int unsigned T_100  = T_100_US  * CYC_PER_US;
  localparam int unsigned T_40   = T_40_US   * CYC_PER_US;
  localparam int unsigned T_1640 = T_1640_US * CYC_PER_US;
  localparam int unsigned T_GAP  = T_GAP_US  * CYC_PER_US;
  localparam int unsigned CNT_W  = $clog2(T_PWR + 1);

  // A state lasting N cycles is entered with N-1 and left when the count hits 0.
  localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] LD_4100 = CNT_W'(T_4100 - 1);
  localparam logic [CNT_W-1:0] LD_100  = CNT_W'(T_100 - 1);
  localparam logic [CNT_W-1:0] LD_40   = CNT_W'(T_40 - 1);
  localparam logic [CNT_W-1:0] LD_1640 = CNT_W'(T_1640 - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP - 1);

  function automatic logic [CNT_W-1:0] init_wait_ld(input logic [1:0] step);
    logic [CNT_W-1:0] ld;
    case (step)
      2'd0:    ld = LD_4100;
      2'd1:    ld = LD_100;
      default: ld = LD_40;
    endcase
    return ld;
  endfunction

  function automatic logic [CNT_W-1:0] exec_wait_ld(input logic rs, input logic [7:0] d);
    return is_slow_opcode(rs, d) ? LD_1640 : LD_40;
  endfunction

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic [1:0]       step_q, step_d;
  logic [1:0]       cfg_idx_q, cfg_idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             init_done_q, init_done_d;

  logic             nib_start, nib_rs, nib_done;
  logic [3:0]       nib_val;
  logic [7:0]       cfg_b;

  assign cnt_dec = cnt_q - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    cfg_idx_d   = cfg_idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = INIT_NIB;
          step_d  = 2'd0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      INIT_NIB: begin
        if (nib_done) begin
          state_d = INIT_WAIT;
          cnt_d   = init_wait_ld(step_q);
        end
      end
      INIT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else if (step_q != 2'd3) begin
          state_d = INIT_NIB;
          step_d  = step_q + 2'd1;
        end else if (AUTO_CONFIG) begin
          state_d   = CFG_HI;
          cfg_idx_d = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CFG_HI: begin
        if (nib_done) begin
          state_d = CFG_GAP;
          cnt_d   = LD_GAP;
        end
      end
      CFG_GAP: begin
        if (cnt_q == '0) state_d = CFG_LO;
        else             cnt_d   = cnt_dec;
      end
      CFG_LO: begin
        if (nib_done) begin
          state_d = CFG_WAIT;
          cnt_d   = exec_wait_ld(1'b0, cfg_byte(cfg_idx_q));
        end
      end
      CFG_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else if (cfg_idx_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          state_d   = CFG_HI;
          cfg_idx_d = cfg_idx_q + 2'd1;
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          state_d = TX_HI;
          rs_d    = cmd_rs;
          data_d  = cmd_data;
        end
      end
      TX_HI: begin
        if (nib_done) begin
          state_d = TX_GAP;
          cnt_d   = LD_GAP;
        end
      end
      TX_GAP: begin
        if (cnt_q == '0) state_d = TX_LO;
        else             cnt_d   = cnt_dec;
      end
      TX_LO: begin
        if (nib_done) begin
          state_d = TX_WAIT;
          cnt_d   = exec_wait_ld(rs_q, data_q);
        end
      end
      TX_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_dec;
      end
      default: state_d = PWR_WAIT;
    endcase
    if (state_d == IDLE) init_done_d = 1'b1;
  end

  // The writer is kicked on the edge that enters a nibble state, so the nibble
  // is selected from the next-state view.
  always_comb begin
    nib_val = 4'h0;
    nib_rs  = 1'b0;
    cfg_b   = cfg_byte(cfg_idx_d);
    unique case (state_d)
      INIT_NIB: nib_val = init_nibble(step_d);
      CFG_HI:   nib_val = cfg_b[7:4];
      CFG_LO:   nib_val = cfg_b[3:0];
      TX_HI: begin
        nib_val = data_d[7:4];
        nib_rs  = rs_d;
      end
      TX_LO: begin
        nib_val = data_d[3:0];
        nib_rs  = rs_d;
      end
      default: nib_val = 4'h0;
    endcase
    nib_start = (state_d != state_q) &&
                (state_d inside {INIT_NIB, CFG_HI, CFG_LO, TX_HI, TX_LO});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= LD_PWR;
      step_q      <= 2'd0;
      cfg_idx_q   <= 2'd0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      cfg_idx_q   <= cfg_idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  lcd_nibble_writer #(
    .SETUP_CYC  (SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC)
  ) u_nibble_writer (
    .clk   (clk),
    .reset (reset),
    .start (nib_start),
    .rs    (nib_rs),
    .nibble(nib_val),
    .done  (nib_done),
    .lcd_e (lcd_e),
    .lcd_rs(lcd_rs),
    .lcd_d (lcd_d)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl_4bit.sv
// Directed bench for lcd_ctrl_4bit at 1 MHz (one cycle per microsecond) so the
// full power-on sequence fits a short run; a second instance covers AUTO_CONFIG=0.
module tb_lcd_ctrl_4bit;

  localparam int NIB_W  = 12;
  localparam int T_40   = 40;
  localparam int T_1640 = 1640;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  logic       cmd_valid, cmd_ready, cmd_rs, init_done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] cmd_data;
  logic [3:0] lcd_d;

  lcd_ctrl_4bit #(
    .CLK_FREQ_HZ(1_000_000), .E_PULSE_CYC(12), .SETUP_CYC(2), .AUTO_CONFIG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  logic       b_cmd_valid = 1'b0, b_cmd_rs = 1'b0;
  logic [7:0] b_cmd_data = 8'h00;
  logic       b_cmd_ready, b_init_done, b_busy, b_lcd_e, b_lcd_rs, b_lcd_rw;
  logic [3:0] b_lcd_d;

  lcd_ctrl_4bit #(
    .CLK_FREQ_HZ(1_000_000), .E_PULSE_CYC(12), .SETUP_CYC(2), .AUTO_CONFIG(1'b0)
  ) dut_nocfg (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_rs(b_cmd_rs), .cmd_data(b_cmd_data), .init_done(b_init_done), .busy(b_busy),
    .lcd_e(b_lcd_e), .lcd_rs(b_lcd_rs), .lcd_rw(b_lcd_rw), .lcd_d(b_lcd_d)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- E-pulse monitor (main DUT) ----------------
  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         rise;
    int         width;
    logic [2:0] shape;  // {setup stable, hold ok, back to zero}
  } pulse_t;

  pulse_t     pq[$];
  logic       e_p, pending, cur_rs, cur_setup, cur_stable;
  logic [3:0] d_p1, d_p2, cur_nib, hold_d;
  int         cur_rise, hi_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      e_p <= 1'b0; pending <= 1'b0; d_p1 <= 4'h0; d_p2 <= 4'h0;
    end else begin
      d_p1 <= lcd_d;
      d_p2 <= d_p1;
      e_p  <= lcd_e;
      if (lcd_e && !e_p) begin
        cur_nib    <= lcd_d;
        cur_rs     <= lcd_rs;
        cur_rise   <= cyc;
        cur_setup  <= (d_p1 == lcd_d) && (d_p2 == lcd_d);
        cur_stable <= 1'b1;
        hi_cnt     <= 1;
      end else if (lcd_e) begin
        hi_cnt <= hi_cnt + 1;
        if (lcd_d != cur_nib || lcd_rs != cur_rs) cur_stable <= 1'b0;
      end
      if (!lcd_e && e_p) begin
        hold_d  <= lcd_d;
        pending <= 1'b1;
      end
      if (pending) begin
        pq.push_back('{nib: cur_nib, rs: cur_rs, rise: cur_rise, width: hi_cnt,
                       shape: {cur_setup && cur_stable, hold_d == cur_nib, lcd_d == 4'h0}});
        pending <= 1'b0;
      end
    end
  end

  // ---------------- monitor (AUTO_CONFIG=0 DUT) ----------------
  logic        b_e_p, b_done_seen;
  logic [15:0] b_seq;
  int          b_cnt, b_done_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      b_e_p <= 1'b0; b_done_seen <= 1'b0; b_seq <= 16'h0; b_cnt <= 0; b_done_cyc <= -1;
    end else begin
      b_e_p <= b_lcd_e;
      if (b_lcd_e && !b_e_p) begin
        b_cnt <= b_cnt + 1;
        b_seq <= {b_seq[11:0], b_lcd_d};
      end
      if (b_init_done && !b_done_seen) begin
        b_done_seen <= 1'b1;
        b_done_cyc  <= cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic get_pulse(input string name, input int limit, output pulse_t p, output bit ok);
    for (int i = 0; i < limit && pq.size() == 0; i++) @(negedge clk);
    if (pq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no E pulse within %0d cycles, expected one", name, limit);
      ok = 1'b0;
    end else begin
      p  = pq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic expect_pulse(input string tag, input int limit, input logic [3:0] nib,
                              input logic rs, input int rise);
    pulse_t p;
    bit     ok;
    get_pulse(tag, limit, p, ok);
    if (ok) begin
      check({tag, " nibble"}, 32'(p.nib), 32'(nib));
      check({tag, " rs"}, 32'(p.rs), 32'(rs));
      check({tag, " rise cycle"}, 32'(p.rise), 32'(rise));
      check({tag, " e width"}, 32'(p.width), 32'(NIB_W));
      check({tag, " setup/hold"}, 32'(p.shape), 32'(3'b111));
    end
  endtask

  task automatic wait_ready(input string name, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: cmd_ready stayed 0 for %0d cycles, expected 1", name, limit);
    end
  endtask

  // Presents one byte for a single cycle; h is the handshake edge count.
  task automatic send_byte(input logic rs, input logic [7:0] d, output int h);
    int at;
    wait_ready("send ready", 5000, at);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    @(negedge clk);
    h = cyc;
    cmd_valid = 1'b0;
    cmd_data  = 8'hA5;
    check("cmd_ready after accept", 32'(cmd_ready), 32'(1'b0));
    check("busy after accept", 32'(busy), 32'(1'b1));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0] nib;
    int         rise;
  } init_vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_c;
  } tx_vec_t;

  init_vec_t init_tab[12];
  tx_vec_t   tx_tab[7];

  initial begin : main
    int h, h1, h2, at;

    // Rise cycles: first at T_PWR+2; rise-to-rise is 15+wait between bytes/steps
    // and 15+T_GAP between the two nibbles of a byte.
    init_tab[0]  = '{4'h3, 15002};
    init_tab[1]  = '{4'h3, 19117};
    init_tab[2]  = '{4'h3, 19232};
    init_tab[3]  = '{4'h2, 19287};
    init_tab[4]  = '{4'h2, 19342};
    init_tab[5]  = '{4'h8, 19358};
    init_tab[6]  = '{4'h0, 19413};
    init_tab[7]  = '{4'h6, 19429};
    init_tab[8]  = '{4'h0, 19484};
    init_tab[9]  = '{4'hC, 19500};
    init_tab[10] = '{4'h0, 19555};
    init_tab[11] = '{4'h1, 19571};

    tx_tab[0] = '{1'b1, 8'h41, T_40};
    tx_tab[1] = '{1'b0, 8'h01, T_1640};
    tx_tab[2] = '{1'b0, 8'h02, T_1640};
    tx_tab[3] = '{1'b0, 8'h03, T_1640};
    tx_tab[4] = '{1'b1, 8'h01, T_40};
    tx_tab[5] = '{1'b0, 8'h04, T_40};
    tx_tab[6] = '{1'b0, 8'h80, T_40};

    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    reset     = 1'b0;
    repeat (5) @(negedge clk);

    check("reset lcd_e", 32'(lcd_e), 32'(1'b0));
    check("reset lcd_rs", 32'(lcd_rs), 32'(1'b0));
    check("reset lcd_rw", 32'(lcd_rw), 32'(1'b0));
    check("reset lcd_d", 32'(lcd_d), 32'(4'h0));
    check("reset init_done", 32'(init_done), 32'(1'b0));
    check("reset cmd_ready", 32'(cmd_ready), 32'(1'b0));
    check("reset busy", 32'(busy), 32'(1'b1));
    reset = 1'b1;

    // Power-on nibbles followed by the configuration bytes.
    for (int i = 0; i < 12; i++)
      expect_pulse($sformatf("init pulse %0d", i), 20000, init_tab[i].nib, 1'b0, init_tab[i].rise);

    at = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("init_done cycle", 32'(at), 32'(19571 + 13 + T_1640));
    check("ready after init", 32'(cmd_ready), 32'(1'b1));
    check("busy after init", 32'(busy), 32'(1'b0));
    check("lcd_rw after init", 32'(lcd_rw), 32'(1'b0));

    check("nocfg pulse count", 32'(b_cnt), 32'(4));
    check("nocfg nibble seq", 32'(b_seq), 32'(16'h3332));
    check("nocfg init_done cycle", 32'(b_done_cyc), 32'(19287 + 13 + T_40));
    check("nocfg cmd_ready", 32'(b_cmd_ready), 32'(1'b1));

    // Table of single-byte transfers.
    for (int i = 0; i < 7; i++) begin
      send_byte(tx_tab[i].rs, tx_tab[i].data, h);
      expect_pulse($sformatf("tx%0d hi", i), 2000, tx_tab[i].data[7:4], tx_tab[i].rs, h + 2);
      expect_pulse($sformatf("tx%0d lo", i), 2000, tx_tab[i].data[3:0], tx_tab[i].rs, h + 18);
      wait_ready($sformatf("tx%0d done", i), 3000, at);
      check($sformatf("tx%0d ready cycle", i), 32'(at), 32'(h + 31 + tx_tab[i].wait_c));
      check($sformatf("tx%0d init_done sticky", i), 32'(init_done), 32'(1'b1));
    end

    // cmd_valid held across two bytes: one acceptance per IDLE visit.
    wait_ready("b2b ready", 5000, at);
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h48;
    @(negedge clk);
    h1 = cyc;
    cmd_data = 8'h49;
    wait_ready("b2b second ready", 3000, at);
    @(negedge clk);
    h2 = cyc;
    cmd_valid = 1'b0;
    check("b2b second accept cycle", 32'(h2), 32'(h1 + 31 + T_40 + 1));
    expect_pulse("b2b 1 hi", 2000, 4'h4, 1'b1, h1 + 2);
    expect_pulse("b2b 1 lo", 2000, 4'h8, 1'b1, h1 + 18);
    expect_pulse("b2b 2 hi", 2000, 4'h4, 1'b1, h2 + 2);
    expect_pulse("b2b 2 lo", 2000, 4'h9, 1'b1, h2 + 18);
    wait_ready("b2b done", 3000, at);
    repeat (100) @(negedge clk);
    check("b2b no extra pulses", 32'(pq.size()), 32'(0));

    // Reset while E is high on the low nibble.
    send_byte(1'b0, 8'h35, h);
    while (cyc < h + 20) @(negedge clk);
    check("mid-tx lcd_e high", 32'(lcd_e), 32'(1'b1));
    #2 reset = 1'b0;
    #1;
    check("async reset lcd_e", 32'(lcd_e), 32'(1'b0));
    check("async reset init_done", 32'(init_done), 32'(1'b0));
    check("async reset lcd_d", 32'(lcd_d), 32'(4'h0));
    check("async reset cmd_ready", 32'(cmd_ready), 32'(1'b0));
    @(negedge clk);
    pq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_pulse("restart pulse 0", 20000, 4'h3, 1'b0, 15002);
    check("restart init_done low", 32'(init_done), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_ctrl_4bit.md
Name: lcd_ctrl_4bit

Overview:
Parametrised successor to the LCD power-on initialisation FSM. It is clock-frequency independent and runs the full 4-bit-interface power-on sequence. An optional automatic configuration phase follows it. After that, the block accepts 8-bit command or data bytes over a valid/ready handshake and sends each byte as two timed nibbles. It sits between the display-text sequencer and the character-LCD pins (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency. CYC_PER_US = CLK_FREQ_HZ/1_000_000; must be an integer ≥ 1.
E_PULSE_CYC, 12, LCD_E high time in cycles (≥ 230 ns at 50 MHz).
SETUP_CYC, 2, cycles that RS/data are stable before E rises.
AUTO_CONFIG, 1, 1 = issue the internal configuration bytes 0x28, 0x06, 0x0C, 0x01 before init_done; 0 = assert init_done straight after the nibble sequence.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  upstream byte valid
cmd_ready  out  1  block accepts a byte this cycle
cmd_rs  in  1  0 = instruction, 1 = DDRAM/CGRAM data
cmd_data  in  8  byte to send
init_done  out  1  power-on (+ optional config) sequence complete; sticky until reset
busy  out  1  high whenever cmd_ready is low
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  constant 0 (write only)
lcd_d  out  4  LCD data nibble (SF_D[11:8])

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, init_done=0, cmd_ready=0, busy=1. All registers clear asynchronously on reset low. The sequence restarts at PWR_WAIT on release.
- Reset mid-operation: any transfer in flight is abandoned, lcd_e drops to 0 immediately, and the captured byte is discarded.
- Delay counts (CYC_PER_US multiples):
  - T_PWR = 15000·CYC_PER_US
  - T_4100 = 4100·CYC_PER_US
  - T_100 = 100·CYC_PER_US
  - T_40 = 40·CYC_PER_US
  - T_1640 = 1640·CYC_PER_US
  - T_GAP = 1·CYC_PER_US
  - At 50 MHz these are 750000, 205000, 5000, 2000, 82000 and 50.
- The single down-counter is sized by $clog2(T_PWR+1). It is loaded on each state entry and the state advances when it reaches 0.
- Nibble write (shared by all paths):
  - lcd_rs/lcd_d are driven for SETUP_CYC cycles, then lcd_e is held 1 for E_PULSE_CYC cycles, then lcd_e=0 with data held 1 more cycle.
  - Total = SETUP_CYC+E_PULSE_CYC+1 cycles.
  - lcd_d returns to 0 after the hold cycle.
- Main FSM states: PWR_WAIT, INIT_NIB, INIT_WAIT, CFG_HI, CFG_GAP, CFG_LO, CFG_WAIT, IDLE, TX_HI, TX_GAP, TX_LO, TX_WAIT.
- Power-on sequence:
  - PWR_WAIT lasts T_PWR.
  - Then four nibbles with rs=0: 0x3 then wait T_4100; 0x3 then wait T_100; 0x3 then wait T_40; 0x2 then wait T_40.
  - INIT_NIB/INIT_WAIT are indexed by a 2-bit step counter.
- Config phase (AUTO_CONFIG=1): the bytes 0x28, 0x06, 0x0C, 0x01 are sent as instructions using the byte-transfer rules below, and a 2-bit index selects the byte. With AUTO_CONFIG=0 the FSM goes directly to IDLE.
- IDLE: init_done=1 (sticky) and cmd_ready=1.
  - A handshake occurs on the cycle where cmd_valid && cmd_ready are both 1. cmd_rs/cmd_data are captured on that edge and cmd_ready=0 from the next cycle.
  - cmd_valid while cmd_ready=0 is ignored and the upstream holds it.
- Byte transfer:
  - Upper nibble, then wait T_GAP, then lower nibble, then execution wait.
  - The execution wait is T_1640 if rs=0 and data ∈ {0x01, 0x02, 0x03}, else T_40.
  - Back to IDLE afterwards; cmd_ready rises on the cycle after the wait ends.
- Back-to-back: cmd_valid held high gets exactly one byte accepted per visit to IDLE. There is no byte skipping and no double capture.
- lcd_rs is held at the captured rs for the whole byte.

Decomposition:
- Package lcd_pkg:
  - FSM state encoding.
  - Timing constants in µs (15000, 4100, 100, 40, 1640, 1).
  - Init nibble table {3,3,3,2} and config byte table {0x28,0x06,0x0C,0x01}.
  - Slow-opcode list {0x01,0x02,0x03}.
- Sub-module lcd_nibble_writer:
  - Inputs: start, rs, nibble. Outputs: done, lcd_e, lcd_rs, lcd_d.
  - Implements the setup/pulse/hold timing and is reused by the init, config and TX paths.

Test Plan:
1. Reset low for 5 cycles, then high; CLK_FREQ_HZ=50e6, AUTO_CONFIG=0 -> lcd_e=0 for 750000 cycles, then nibble 0x3 with lcd_e high for exactly 12 cycles, starting 2 cycles after lcd_d=0x3. Next E rise follows 205000 wait cycles.
2. Same setup, run to completion -> nibble sequence 3,3,3,2 with the waits above; init_done rises and cmd_ready=1. Count 4 E pulses total.
3. AUTO_CONFIG=1 -> 8 extra E pulses after the power-on sequence carrying nibbles 2,8,0,6,0,C,0,1. The gap after the final byte (0x01) is ≥ 82000 cycles before init_done=1.
4. After init, cmd_rs=1, cmd_data=0x41, valid for 1 cycle -> lcd_rs=1; nibbles 0x4 then 0x1 separated by ≥ 50 idle cycles; cmd_ready returns after 2000 cycles. Second byte 0x01 with rs=0 -> 82000-cycle wait.
5. cmd_valid held high with data 0x48, 0x49 presented back-to-back -> each accepted exactly once; 4 E pulses seen in order 4,8,4,9.
6. Reset asserted while lcd_e=1 during TX_LO -> lcd_e=0 asynchronously and init_done=0. On release the sequence restarts with a 750000-cycle PWR_WAIT.
